// File: rtl/rst_seq_pkg.sv
// Shared types and default sizing for the staged domain reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } seq_state_e;

  localparam int DEF_SYNC_STAGES = 3;
  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_STAGE_GAP   = 16;

endpackage

// File: rtl/rst_sync_cell.sv
// Multi-flop synchronizer for one asynchronous level input; clears to 0 asynchronously.
module rst_sync_cell #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_chain;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/rst_domain_sequencer.sv
// Staged reset release for one clock domain: HOLD -> RELEASE (one stage per gap) -> RUN.
// Define RST_SEQ_LOCK_MON_EN to gate release on PLL lock and abort/flag on lock loss.
module rst_domain_sequencer
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  por_rst_n_in,
  input  logic                  pll_locked_in,
  output logic [NUM_STAGES-1:0] stage_rst_out,
  output logic                  seq_done_out,
  output logic                  lock_lost_out
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CNT_W = $clog2(STAGE_GAP + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(STAGE_GAP - 1);

  seq_state_e             r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_cnt;
  logic [NUM_STAGES-1:0]  r_stage_rst;
  logic                   r_done;
  logic                   r_lock_lost;

  seq_state_e             w_state_next;
  logic [IDX_W-1:0]       w_idx_next;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [NUM_STAGES-1:0]  w_stage_next;
  logic                   w_req;
  logic                   w_abort;
  logic                   w_lost_evt;

  rst_sync_cell #(.DEPTH(SYNC_STAGES)) u_req_sync (
    .i_clk (clk_in),
    .i_clr (rst_in),
    .i_d   (por_rst_n_in),
    .o_q   (w_req)
  );

`ifdef RST_SEQ_LOCK_MON_EN
  logic w_lock;

  rst_sync_cell #(.DEPTH(SYNC_STAGES)) u_lock_sync (
    .i_clk (clk_in),
    .i_clr (rst_in),
    .i_d   (pll_locked_in),
    .o_q   (w_lock)
  );

  // In HOLD a missing lock simply keeps us in HOLD, so one abort term covers all states.
  assign w_abort    = ~w_req | ~w_lock;
  assign w_lost_evt = (r_state == S_RUN) & ~w_lock;
`else
  logic w_unused_pll;

  assign w_unused_pll = pll_locked_in;
  assign w_abort      = ~w_req;
  assign w_lost_evt   = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    if (w_abort) begin
      w_state_next = S_HOLD;
      w_idx_next   = '0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          w_state_next = S_RELEASE;
          w_idx_next   = '0;
          w_cnt_next   = '0;
        end
        S_RELEASE: begin
          if (r_cnt == GAP_END) begin
            w_cnt_next = '0;
            if (r_idx == LAST_IDX) begin
              w_state_next = S_RUN;
            end else begin
              w_idx_next = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          w_state_next = S_RUN;
        end
        default: begin
          w_state_next = S_HOLD;
          w_idx_next   = '0;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Stage k is held while in HOLD, or in RELEASE while k is beyond the last released index.
  always_comb begin
    w_stage_next = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_stage_next[k] = (w_state_next == S_HOLD) ||
                        ((w_state_next == S_RELEASE) && (k > int'(w_idx_next)));
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= S_HOLD;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_stage_rst <= '1;
      r_done      <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_idx       <= w_idx_next;
      r_cnt       <= w_cnt_next;
      r_stage_rst <= w_stage_next;
      r_done      <= (w_state_next == S_RUN);
      r_lock_lost <= w_lost_evt;
    end
  end

  assign stage_rst_out = r_stage_rst;
  assign seq_done_out  = r_done;
  assign lock_lost_out = r_lock_lost;

endmodule

// File: tb/tb_rst_domain_sequencer.sv
// Directed bench for rst_domain_sequencer: default instance plus a NUM_STAGES=1/STAGE_GAP=1 instance.
module tb_rst_domain_sequencer;

  logic       clk;
  logic       rst;
  logic       por_n;
  logic       pll;
  logic [3:0] stage;
  logic       done;
  logic       lost;
  logic [0:0] min_stage;
  logic       min_done;
  logic       min_lost;

  int n_checks;
  int n_pass;
  int cyc;

  rst_domain_sequencer u_dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .por_rst_n_in  (por_n),
    .pll_locked_in (pll),
    .stage_rst_out (stage),
    .seq_done_out  (done),
    .lock_lost_out (lost)
  );

  rst_domain_sequencer #(.SYNC_STAGES(3), .NUM_STAGES(1), .STAGE_GAP(1)) u_dut_min (
    .clk_in        (clk),
    .rst_in        (rst),
    .por_rst_n_in  (por_n),
    .pll_locked_in (pll),
    .stage_rst_out (min_stage),
    .seq_done_out  (min_done),
    .lock_lost_out (min_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
    cyc += n;
  endtask

  task automatic go_to(input int t);
    tick(t - cyc);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst      = 1'b1;
    por_n    = 1'b0;
`ifdef RST_SEQ_LOCK_MON_EN
    pll      = 1'b1;
`else
    pll      = 1'b0;
`endif
    tick(3);
    check_eq("rst_stage", {28'd0, stage}, 32'hF);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_lost", {31'd0, lost}, 32'd0);
    check_eq("rst_min_stage", {31'd0, min_stage}, 32'd1);
    rst = 1'b0;
    tick(5);
    check_eq("hold_no_req", {28'd0, stage}, 32'hF);

    // Nominal release timeline, por rises at cycle 0
    por_n = 1'b1; cyc = 0;
    go_to(3);  check_eq("seq_c3", {28'd0, stage}, 32'hF);
               check_eq("min_c3", {31'd0, min_stage}, 32'd1);
    go_to(4);  check_eq("seq_c4", {28'd0, stage}, 32'hE);
               check_eq("min_c4_stage", {31'd0, min_stage}, 32'd0);
               check_eq("min_c4_done", {31'd0, min_done}, 32'd0);
    go_to(5);  check_eq("min_c5_done", {31'd0, min_done}, 32'd1);
    go_to(19); check_eq("seq_c19", {28'd0, stage}, 32'hE);
    go_to(20); check_eq("seq_c20", {28'd0, stage}, 32'hC);
    go_to(35); check_eq("seq_c35", {28'd0, stage}, 32'hC);
    go_to(36); check_eq("seq_c36", {28'd0, stage}, 32'h8);
    go_to(52); check_eq("seq_c52", {28'd0, stage}, 32'h0);
               check_eq("done_c52", {31'd0, done}, 32'd0);
    go_to(67); check_eq("done_c67", {31'd0, done}, 32'd0);
    go_to(68); check_eq("done_c68", {31'd0, done}, 32'd1);
               check_eq("lost_run", {31'd0, lost}, 32'd0);

    // Request drop while running
    por_n = 1'b0; cyc = 0;
    go_to(3);  check_eq("drop_c3_stage", {28'd0, stage}, 32'h0);
               check_eq("drop_c3_done", {31'd0, done}, 32'd1);
    go_to(4);  check_eq("drop_c4_stage", {28'd0, stage}, 32'hF);
               check_eq("drop_c4_done", {31'd0, done}, 32'd0);
               check_eq("drop_c4_lost", {31'd0, lost}, 32'd0);

    // Abort lands on the same edge stage 2 would release
    tick(2);
    por_n = 1'b1; cyc = 0;
    go_to(32); check_eq("abort_c32", {28'd0, stage}, 32'hC);
    por_n = 1'b0;
    go_to(35); check_eq("abort_c35", {28'd0, stage}, 32'hC);
    go_to(36); check_eq("abort_c36", {28'd0, stage}, 32'hF);
    go_to(37); check_eq("abort_c37", {28'd0, stage}, 32'hF);
               check_eq("abort_done", {31'd0, done}, 32'd0);

    // One captured low cycle of req aborts fully, then restarts
    tick(4);
    por_n = 1'b1; cyc = 0;
    go_to(10); check_eq("glitch_c10", {28'd0, stage}, 32'hE);
    por_n = 1'b0;
    go_to(11);
    por_n = 1'b1;
    go_to(13); check_eq("glitch_c13", {28'd0, stage}, 32'hE);
    go_to(14); check_eq("glitch_c14", {28'd0, stage}, 32'hF);
    go_to(15); check_eq("glitch_c15", {28'd0, stage}, 32'hE);

    // Module reset mid-release with por held high
    go_to(40); check_eq("mid_c40", {28'd0, stage}, 32'hC);
    rst = 1'b1;
    #1;
    check_eq("async_rst_stage", {28'd0, stage}, 32'hF);
    check_eq("async_rst_done", {31'd0, done}, 32'd0);
    tick(2);
    rst = 1'b0; cyc = 0;
    go_to(3);  check_eq("post_rst_c3", {28'd0, stage}, 32'hF);
    go_to(4);  check_eq("post_rst_c4", {28'd0, stage}, 32'hE);
               check_eq("post_rst_min", {31'd0, min_stage}, 32'd0);
    go_to(68); check_eq("post_rst_done", {31'd0, done}, 32'd1);

`ifdef RST_SEQ_LOCK_MON_EN
    pll = 1'b0; cyc = 0;
    go_to(3);  check_eq("lock_c3_lost", {31'd0, lost}, 32'd0);
               check_eq("lock_c3_stage", {28'd0, stage}, 32'h0);
    go_to(4);  check_eq("lock_c4_lost", {31'd0, lost}, 32'd1);
               check_eq("lock_c4_stage", {28'd0, stage}, 32'hF);
               check_eq("lock_c4_done", {31'd0, done}, 32'd0);
    go_to(5);  check_eq("lock_c5_lost", {31'd0, lost}, 32'd0);
    pll = 1'b1; cyc = 0;
    go_to(3);  check_eq("relock_c3", {28'd0, stage}, 32'hF);
    go_to(4);  check_eq("relock_c4", {28'd0, stage}, 32'hE);
    go_to(20); check_eq("relock_c20", {28'd0, stage}, 32'hC);
    go_to(68); check_eq("relock_done", {31'd0, done}, 32'd1);
`else
    check_eq("lost_tied", {31'd0, lost}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
